// File: rtl/paddle_pkg.sv
// Shared types and helpers for the paddle input hub.
// Source/axis enums and the mouse accumulator saturation range.
package paddle_pkg;

  typedef enum logic [1:0] {
    SRC_PADDLE = 2'd0,
    SRC_STICK  = 2'd1,
    SRC_MOUSE  = 2'd2
  } src_t;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_t;

  localparam logic signed [9:0] ACC_MIN = -10'sd128;
  localparam logic signed [9:0] ACC_MAX = 10'sd127;

  function automatic logic signed [8:0] acc_add(
    input logic signed [8:0] acc,
    input logic signed [8:0] d
  );
    logic signed [9:0] s;
    s = {acc[8], acc} + {d[8], d};
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
    return s[8:0];
  endfunction

endpackage

// File: rtl/paddle_chan.sv
// One paddle channel: source FSM, axis select, mouse accumulators
// and the two-stage position pipeline.
module paddle_chan
  import paddle_pkg::*;
#(
  parameter int OUT_W        = 8,
  parameter int STICK_THRESH = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inv,
  input  logic              paddle_btn,
  input  logic              stick_btn,
  input  logic [15:0]       joy,
  input  logic [7:0]        paddle,
  input  logic              mouse_evt,
  input  logic              mouse_sel,
  input  logic [1:0]        mouse_btn,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  output logic [OUT_W-1:0]  a_out,
  output logic              b_out,
  output logic [1:0]        src
);

  localparam logic [7:0] TH = 8'(STICK_THRESH);

  src_t  src_q, src_d;
  axis_t axis_q, axis_d;
  logic signed [8:0] acc_x, acc_y;
  logic [7:0] pre_q, val, pre_v;
  logic [OUT_W-1:0] wide, a_q;
  logic b_q, b_d;
  logic x_hit, y_hit;

  assign x_hit = !joy[7] && (joy[7:0] > TH);
  assign y_hit = !joy[15] && (joy[15:8] > TH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= SRC_PADDLE;
      axis_q <= AXIS_X;
    end else begin
      src_q  <= src_d;
      axis_q <= axis_d;
    end
  end

  always_comb begin
    src_d  = src_q;
    axis_d = axis_q;
    if (paddle_btn)     src_d = SRC_PADDLE;
    else if (stick_btn) src_d = SRC_STICK;
    else if (mouse_evt) src_d = SRC_MOUSE;
    // Stick deflection wins on X when both axes exceed the threshold
    if (src_d == SRC_STICK) begin
      if (x_hit)      axis_d = AXIS_X;
      else if (y_hit) axis_d = AXIS_Y;
    end else if (src_d == SRC_MOUSE && mouse_evt) begin
      if (mouse_btn[0])      axis_d = AXIS_X;
      else if (mouse_btn[1]) axis_d = AXIS_Y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_x <= '0;
      acc_y <= '0;
    end else if (mouse_evt) begin
      acc_x <= acc_add(acc_x, dx);
      acc_y <= acc_add(acc_y, dy);
    end
  end

  always_comb begin
    val = {~paddle[7], paddle[6:0]};
    b_d = paddle_btn;
    unique case (src_q)
      SRC_PADDLE: begin
        val = {~paddle[7], paddle[6:0]};
        b_d = paddle_btn;
      end
      SRC_STICK: begin
        val = (axis_q == AXIS_Y) ? joy[15:8] : joy[7:0];
        b_d = stick_btn;
      end
      SRC_MOUSE: begin
        val = (axis_q == AXIS_Y) ? acc_y[7:0] : acc_x[7:0];
        b_d = mouse_sel && (|mouse_btn);
      end
      default: begin
        val = {~paddle[7], paddle[6:0]};
        b_d = paddle_btn;
      end
    endcase
  end

  assign pre_v = inv ? ~pre_q : pre_q;

  generate
    if (OUT_W > 8) begin : g_wide
      assign wide = {pre_v, pre_v[7 -: OUT_W-8]};
    end else begin : g_narrow
      assign wide = pre_v;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      a_q   <= '0;
      b_q   <= 1'b0;
    end else begin
      pre_q <= val;
      a_q   <= wide;
      b_q   <= b_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign src   = src_q;

endmodule

// File: rtl/paddle_input_hub.sv
// Multi-channel paddle front end: shared mouse strobe tracking
// and delta conditioning feeding NUM_CH paddle_chan instances.
module paddle_input_hub
  import paddle_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int OUT_W        = 8,
  parameter int MOUSE_CLAMP  = 10,
  parameter int MOUSE_SHIFT  = 1,
  parameter int STICK_THRESH = 100,
  parameter int MCW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inv,
  input  logic [NUM_CH-1:0]       stick_btn,
  input  logic [NUM_CH-1:0]       paddle_btn,
  input  logic [16*NUM_CH-1:0]    joy_a,
  input  logic [8*NUM_CH-1:0]     paddle,
  input  logic [24:0]             ps2_mouse,
  input  logic [MCW-1:0]          mouse_ch,
  output logic [OUT_W*NUM_CH-1:0] a_out,
  output logic [NUM_CH-1:0]       b_out,
  output logic [2*NUM_CH-1:0]     src
);

  localparam logic signed [8:0] CLP = 9'(MOUSE_CLAMP);
  localparam logic signed [8:0] CLN = -CLP;

  logic strobe_q, armed_q, evt;
  logic signed [8:0] dx, dy;
  logic unused_bits;

  function automatic logic signed [8:0] clamp_delta(
    input logic       sgn,
    input logic [7:0] raw
  );
    logic signed [8:0] v;
    v = $signed({sgn, raw}) >>> MOUSE_SHIFT;
    if (v > CLP)      v = CLP;
    else if (v < CLN) v = CLN;
    return v;
  endfunction

  // First clock out of reset only captures the strobe level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      strobe_q <= ps2_mouse[24];
      armed_q  <= 1'b1;
    end
  end

  assign evt = armed_q && (ps2_mouse[24] != strobe_q);
  assign dx  = clamp_delta(ps2_mouse[4], ps2_mouse[15:8]);
  assign dy  = clamp_delta(ps2_mouse[5], ps2_mouse[23:16]);

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = (32'(mouse_ch) == 32'(i));

    paddle_chan #(
      .OUT_W       (OUT_W),
      .STICK_THRESH(STICK_THRESH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .inv       (inv),
      .paddle_btn(paddle_btn[i]),
      .stick_btn (stick_btn[i]),
      .joy       (joy_a[16*i +: 16]),
      .paddle    (paddle[8*i +: 8]),
      .mouse_evt (evt && sel),
      .mouse_sel (sel),
      .mouse_btn (ps2_mouse[1:0]),
      .dx        (dx),
      .dy        (dy),
      .a_out     (a_out[OUT_W*i +: OUT_W]),
      .b_out     (b_out[i]),
      .src       (src[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_paddle_input_hub.sv
// Scoreboard bench for paddle_input_hub: a behavioural model
// pushes expected outputs per clock, a monitor pops and compares.
module tb_paddle_input_hub;

  localparam int NCH   = 3;
  localparam int OUT_W = 12;
  localparam int CLAMP = 10;
  localparam int SHIFT = 1;
  localparam int TH    = 100;

  logic                   clk = 0;
  logic                   reset;
  logic                   inv;
  logic [NCH-1:0]         stick_btn, paddle_btn;
  logic [16*NCH-1:0]      joy_a;
  logic [8*NCH-1:0]       paddle;
  logic [24:0]            ps2_mouse;
  logic [1:0]             mouse_ch;
  logic [OUT_W*NCH-1:0]   a_out;
  logic [NCH-1:0]         b_out;
  logic [2*NCH-1:0]       src;

  paddle_input_hub #(
    .NUM_CH(NCH), .OUT_W(OUT_W), .MOUSE_CLAMP(CLAMP),
    .MOUSE_SHIFT(SHIFT), .STICK_THRESH(TH)
  ) dut (
    .clk(clk), .reset(reset), .inv(inv),
    .stick_btn(stick_btn), .paddle_btn(paddle_btn),
    .joy_a(joy_a), .paddle(paddle), .ps2_mouse(ps2_mouse),
    .mouse_ch(mouse_ch), .a_out(a_out), .b_out(b_out), .src(src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W*NCH-1:0] a;
    logic [NCH-1:0]       b;
    logic [2*NCH-1:0]     s;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: 0 paddle / 1 stick / 2 mouse, axis 0 X / 1 Y
  int m_src[NCH], m_axis[NCH], m_accx[NCH], m_accy[NCH];
  int m_pre[NCH], m_a[NCH], m_b[NCH];
  int m_armed, m_last;

  function automatic int widen(int v);
    return ((v << (OUT_W - 8)) | (v >> (16 - OUT_W))) & ((1 << OUT_W) - 1);
  endfunction

  function automatic int delta(int sgn, int raw);
    int v;
    v = sgn ? raw - 256 : raw;
    v = v >>> SHIFT;
    if (v > CLAMP) v = CLAMP;
    if (v < -CLAMP) v = -CLAMP;
    return v;
  endfunction

  function automatic int sat(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic tick();
    exp_t e;
    int ev, mc, p, jx, jy, v, evc, anyb;
    if (reset) begin
      m_armed = 0;
      m_last  = 0;
      for (int c = 0; c < NCH; c++) begin
        m_src[c] = 0; m_axis[c] = 0; m_accx[c] = 0; m_accy[c] = 0;
        m_pre[c] = 0; m_a[c] = 0; m_b[c] = 0;
      end
    end else begin
      ev = (m_armed != 0 && int'(ps2_mouse[24]) != m_last) ? 1 : 0;
      m_armed = 1;
      m_last  = int'(ps2_mouse[24]);
      mc   = int'(mouse_ch);
      anyb = (ps2_mouse[1:0] != 2'b00) ? 1 : 0;
      for (int c = 0; c < NCH; c++) begin
        p  = int'(paddle[8*c +: 8]);
        jx = int'(joy_a[16*c +: 8]);
        jy = int'(joy_a[16*c+8 +: 8]);
        case (m_src[c])
          0:       v = p ^ 8'h80;
          1:       v = m_axis[c] ? jy : jx;
          default: v = (m_axis[c] ? m_accy[c] : m_accx[c]) & 255;
        endcase
        m_a[c] = widen(inv ? (~m_pre[c]) & 255 : m_pre[c]);
        if (m_src[c] == 0)      m_b[c] = int'(paddle_btn[c]);
        else if (m_src[c] == 1) m_b[c] = int'(stick_btn[c]);
        else                    m_b[c] = (mc == c) ? anyb : 0;
        m_pre[c] = v;
        evc = (ev != 0 && mc == c) ? 1 : 0;
        if (evc != 0) begin
          m_accx[c] = sat(m_accx[c] + delta(ps2_mouse[4], ps2_mouse[15:8]));
          m_accy[c] = sat(m_accy[c] + delta(ps2_mouse[5], ps2_mouse[23:16]));
        end
        if (paddle_btn[c])     m_src[c] = 0;
        else if (stick_btn[c]) m_src[c] = 1;
        else if (evc != 0)     m_src[c] = 2;
        if (m_src[c] == 1) begin
          if (jx < 128 && jx > TH)      m_axis[c] = 0;
          else if (jy < 128 && jy > TH) m_axis[c] = 1;
        end else if (m_src[c] == 2 && evc != 0) begin
          if (ps2_mouse[0])      m_axis[c] = 0;
          else if (ps2_mouse[1]) m_axis[c] = 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      e.a[OUT_W*c +: OUT_W] = OUT_W'(m_a[c]);
      e.b[c]                = m_b[c][0];
      e.s[2*c +: 2]         = 2'(m_src[c]);
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("a_out", 32'(a_out), 32'(e.a));
        chk("b_out", 32'(b_out), 32'(e.b));
        chk("src",   32'(src),   32'(e.s));
      end
    end
  end

  task automatic toggle(int n);
    for (int k = 0; k < n; k++) begin
      ps2_mouse[24] = ~ps2_mouse[24];
      tick();
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin : driver
    reset = 1; inv = 0; stick_btn = '0; paddle_btn = '0;
    joy_a = '0; paddle = '0; ps2_mouse = '0; mouse_ch = '0;
    @(negedge clk);
    idle(2);
    reset = 0;
    idle(3);
    chk("reset_paddle0", 32'(a_out[11:0]), 32'h808);
    chk("reset_src", 32'(src), 32'h0);
    chk("reset_b", 32'(b_out), 32'h0);

    mouse_ch = 2'd1;
    ps2_mouse[15:8] = 8'd40;
    toggle(3);
    idle(3);
    chk("mouse_acc30", 32'(a_out[23:12]), 32'h1E1);
    chk("mouse_src", 32'(src[3:2]), 32'd2);
    chk("ch0_untouched", 32'(a_out[11:0]), 32'h808);

    ps2_mouse[4] = 1'b1;
    ps2_mouse[15:8] = 8'h01;
    toggle(100);
    idle(3);
    chk("mouse_sat", 32'(a_out[23:12]), 32'h808);
    inv = 1;
    idle(2);
    chk("mouse_sat_inv", 32'(a_out[23:12]), 32'h7F7);
    inv = 0;

    joy_a[47:32] = {8'd110, 8'd20};
    stick_btn[2] = 1'b1;
    tick();
    stick_btn[2] = 1'b0;
    idle(3);
    chk("stick_axis_y", 32'(a_out[35:24]), 32'h6E6);
    chk("stick_src", 32'(src[5:4]), 32'd1);
    stick_btn[2] = 1'b1;
    paddle_btn[2] = 1'b1;
    tick();
    stick_btn[2] = 1'b0;
    paddle_btn[2] = 1'b0;
    idle(1);
    chk("paddle_priority", 32'(src[5:4]), 32'd0);

    reset = 1;
    ps2_mouse[24] = 1'b1;
    idle(2);
    reset = 0;
    idle(3);
    chk("no_event_after_reset", 32'(src), 32'h0);

    paddle[7:0] = 8'hFF;
    idle(3);
    chk("widen_ff", 32'(a_out[11:0]), 32'h7F7);
    mouse_ch = 2'd3;
    toggle(5);
    idle(1);
    chk("mouse_ch_out_of_range", 32'(src), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) inv = ~inv;
      for (int c = 0; c < NCH; c++) begin
        paddle_btn[c] = ($urandom_range(0, 9) == 0);
        stick_btn[c]  = ($urandom_range(0, 9) == 0);
      end
      joy_a    = {$urandom, $urandom};
      paddle   = 24'($urandom);
      ps2_mouse[23:0] = 24'($urandom);
      if ($urandom_range(0, 2) == 0) ps2_mouse[24] = ~ps2_mouse[24];
      if ($urandom_range(0, 19) == 0) mouse_ch = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 0; paddle_btn = '0; stick_btn = '0;
    idle(3);
    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
